ddr_rd_arbiter: RTL
===================

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: width of AXI read addresses.
REQ-002 The block SHALL have parameter DATA_W, default 32: width of AXI read data.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every register samples on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port s_araddr, input, 2*ADDR_W bits: read addresses from requesters; requester 0 on the low slice, requester 1 on the high slice.
REQ-006 The block SHALL have port s_arlen, input, 2*8 bits: burst lengths from requesters, same slice order.
REQ-007 The block SHALL have port s_arvalid, input, 2 bits: per-requester address valid.
REQ-008 The block SHALL have port s_arready, output, 2 bits: per-requester address accept.
REQ-009 The block SHALL have port s_rdata, output, DATA_W bits: read data, broadcast to both requesters.
REQ-010 The block SHALL have port s_rresp, output, 2 bits: read response, broadcast.
REQ-011 The block SHALL have port s_rlast, output, 1 bit: last beat, broadcast.
REQ-012 The block SHALL have port s_rvalid, output, 2 bits: per-requester data valid.
REQ-013 The block SHALL have port s_rready, input, 2 bits: per-requester data ready.
REQ-014 The block SHALL drive the DDR AXI read master ports m_axi_arid (1 bit, equal to the granted index), m_axi_araddr, m_axi_arlen, m_axi_arsize (constant 3'b010), m_axi_arburst (constant 2'b01), m_axi_arvalid and m_axi_rready as outputs.
REQ-015 The block SHALL take m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast and m_axi_rvalid as inputs.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, ADDR and DATA, and SHALL allow exactly one outstanding burst.
REQ-017 In IDLE, when any s_arvalid bit is 1, the FSM SHALL register the grant index plus the granted address and length, then enter ADDR.
REQ-018 When both requesters are valid in IDLE, the grant SHALL go to the requester that was not granted last.
REQ-019 In ADDR, m_axi_arvalid SHALL be 1, which places it 1 cycle after grant; on m_axi_arvalid&&m_axi_arready the FSM SHALL pulse s_arready[grant] for that cycle and enter DATA.
REQ-020 s_arready[i] SHALL be 0 in every cycle except the ADDR handshake cycle of the granted requester.
REQ-021 In DATA, s_rvalid[grant] SHALL equal m_axi_rvalid, m_axi_rready SHALL equal s_rready[grant], and the other s_rvalid bit SHALL be 0.
REQ-022 On the beat where m_axi_rvalid, m_axi_rready and m_axi_rlast are all 1, the FSM SHALL update the last-grant register and return to IDLE.
REQ-023 A requester deasserting s_arvalid while it waits ungranted SHALL be ignored; arvalid SHALL be re-sampled only in IDLE.
REQ-024 A new grant SHALL be possible on the cycle after the rlast handshake, giving 1 idle cycle between bursts.
REQ-025 m_axi_arlen SHALL be passed through unmodified, so arlen=0 is a single-beat burst.

Reset
REQ-026 While rst=1 the FSM SHALL be in IDLE, the last-grant register SHALL be 1 so that requester 0 wins first, and m_axi_arvalid, m_axi_rready, s_arready and s_rvalid SHALL all be 0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst; the DDR model is required to be reset in the same cycle.

Configuration
REQ-028 When DDR_ARB_RR_EN is defined, the block SHALL use round-robin arbitration as in REQ-018.
REQ-029 When DDR_ARB_RR_EN is not defined, requester 0 SHALL always win when both are valid, and the last-grant register SHALL be omitted.

Structure
REQ-030 The FSM state encoding and the AXI constants ARSIZE_32 and ARBURST_INCR SHALL live in the shared package.
REQ-031 Grant selection SHALL be one sub-module, arb_rr2: 2-bit request and last-grant register in, grant index and valid out.

Verification
REQ-032 Single request: s_arvalid=01, araddr=0x100, arlen=3 -> m_axi_arvalid=1 one cycle later with araddr=0x100 and arid=0; 4 beats reach only requester 0; IDLE after rlast.
REQ-033 Simultaneous requests: s_arvalid=11 after reset -> grant 0 first, then grant 1; with DDR_ARB_RR_EN and both held, grants alternate 0,1,0,1.
REQ-034 Backpressure: s_rready[grant] toggles 1,0,1,0 over a 4-beat burst -> m_axi_rready mirrors it and no beat is lost or duplicated.
REQ-035 arlen=0 burst -> exactly 1 beat with rlast=1 and return to IDLE.
REQ-036 rst pulsed in DATA after 2 of 8 beats -> the cycle after rst, all valid and ready outputs are 0 and state is IDLE.
REQ-037 Without DDR_ARB_RR_EN, both requesters held valid -> requester 0 is granted every time and requester 1 is never granted.

Source files
------------

// File: rtl/ddr_rd_arbiter_pkg.sv
// Shared definitions for the two-requester DDR read arbiter.
//   state_e      : arbiter FSM state encoding (idle, address phase, data phase)
//   ARSIZE_32    : AXI ARSIZE for 4-byte beats
//   ARBURST_INCR : AXI ARBURST for incrementing bursts
package ddr_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  localparam logic [2:0] ARSIZE_32    = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// AXI read-channel bundle between the arbiter and the DDR controller.
//   master modport : arbiter side; drives AR channel and rready
//   slave modport  : DDR side; drives arready and the R channel
// Parameters:
//   ADDR_W : read address width
//   DATA_W : read data width
interface ddr_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/ddr_rd_arbiter_arb_rr2.sv
// Two-way grant selector.
//   req_i        : request vector (bit i = requester i valid)
//   last_grant_i : index granted most recently; loses a tie
//   grant_o      : selected requester index
//   valid_o      : at least one request present
// Tying last_grant_i high turns this into fixed priority for requester 0.
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Arbitrates AXI read bursts from two requesters onto one DDR read port,
// one outstanding burst at a time.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   s_araddr   : requester addresses, requester 0 in the low slice
//   s_arlen    : requester burst lengths, same slice order
//   s_arvalid  : per-requester address valid
//   s_arready  : per-requester address accept (pulses on the DDR AR handshake)
//   s_rdata, s_rresp, s_rlast : read data channel, broadcast to both requesters
//   s_rvalid   : per-requester data valid (only the granted bit can be set)
//   s_rready   : per-requester data ready
//   m_axi      : DDR AXI read master bundle
// Build option:
//   DDR_ARB_RR_EN defined   -> round-robin on simultaneous requests
//   DDR_ARB_RR_EN undefined -> requester 0 always wins ties, no last-grant state
module ddr_rd_arbiter
  import ddr_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  input  logic [15:0]           s_arlen,
  input  logic [1:0]            s_arvalid,
  output logic [1:0]            s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic [1:0]            s_rvalid,
  input  logic [1:0]            s_rready,
  ddr_rd_arbiter_if.master      m_axi
);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic              last_grant;
  logic              arb_grant;
  logic              arb_valid;
  logic              in_addr;
  logic              in_data;
  logic              rready_int;

`ifdef DDR_ARB_RR_EN
  logic last_q, last_d;
  assign last_grant = last_q;
`else
  // Requester 1 "was last" forever, so requester 0 always wins a tie.
  assign last_grant = 1'b1;
`endif

  arb_rr2 u_arb (
    .req_i        (s_arvalid),
    .last_grant_i (last_grant),
    .grant_o      (arb_grant),
    .valid_o      (arb_valid)
  );

  // Outputs are gated with rst so nothing is offered while reset is held.
  assign in_addr    = (state_q == StAddr) && !rst;
  assign in_data    = (state_q == StData) && !rst;
  assign rready_int = in_data && s_rready[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
`ifdef DDR_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_grant;
          addr_d  = arb_grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
          len_d   = arb_grant ? s_arlen[15:8] : s_arlen[7:0];
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (m_axi.arready) begin
          state_d = StData;
        end
      end
      StData: begin
        if (m_axi.rvalid && rready_int && m_axi.rlast) begin
          state_d = StIdle;
`ifdef DDR_ARB_RR_EN
          last_d  = grant_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
`ifdef DDR_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
`ifdef DDR_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign m_axi.arid    = grant_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = ARSIZE_32;
  assign m_axi.arburst = ARBURST_INCR;
  assign m_axi.arvalid = in_addr;
  assign m_axi.rready  = rready_int;

  assign s_rdata = m_axi.rdata;
  assign s_rresp = m_axi.rresp;
  assign s_rlast = m_axi.rlast;

  always_comb begin
    s_arready = 2'b00;
    s_rvalid  = 2'b00;
    if (in_addr && m_axi.arready) begin
      s_arready[grant_q] = 1'b1;
    end
    if (in_data && m_axi.rvalid) begin
      s_rvalid[grant_q] = 1'b1;
    end
  end

endmodule
